mmio_arbiter: RTL and testbench
===============================

MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 Param: ADDR_W, default 26, MMIO word-address width.
REQ-002 Param: DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 Clock and reset: one clock, i_clk; reset is asynchronous and active-low, i_rst_n.
REQ-004 Ports, clock and reset first:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_req  in  2  per-requester request; held until grant
- i_addr0/i_addr1  in  ADDR_W each  request address
- i_wdata0/i_wdata1  in  DATA_W each  write data
- i_byte_we0/i_byte_we1  in  DATA_W/8 each  byte write enables
- i_read_en0/i_read_en1  in  1 each  read strobe (side-effecting reads)
- o_gnt  out  2  one-cycle accept pulse
- o_rvalid  out  2  one-cycle read-data pulse
- o_rdata  out  DATA_W  read data, shared, qualified by o_rvalid
- o_addr  out  ADDR_W  downstream address
- o_data  out  DATA_W  downstream write data
- o_byte_we  out  DATA_W/8  downstream byte enables
- o_read_en  out  1  downstream read strobe
- i_rdata  in  DATA_W  downstream read data, valid one cycle after the access

Function
REQ-005 FSM states: IDLE, ISSUE, RESP.
REQ-006 IDLE: if i_req is nonzero, select a winner, latch its addr/wdata/byte_we/read_en, pulse o_gnt[winner] for one cycle, go to ISSUE. Otherwise stay in IDLE.
REQ-007 ISSUE: drive latched fields on o_addr/o_data/o_byte_we/o_read_en for exactly one cycle.
- Latched byte_we nonzero: write; o_read_en=0; next state IDLE.
- Otherwise: read; o_read_en = latched read_en; next state RESP.
REQ-008 RESP: capture i_rdata into o_rdata, pulse o_rvalid[winner] for one cycle, go to IDLE.
REQ-009 Downstream outputs are registered and are zero in every cycle other than ISSUE. A strobe is never repeated, so an RX FIFO is never double-popped.
REQ-010 Latency from request to downstream access: o_gnt is asserted one cycle after i_req is seen in IDLE; the access follows in the next cycle.
- Write: 2 cycles per transaction.
- Read: o_rvalid is asserted 2 cycles after o_gnt; 3 cycles per transaction.
REQ-011 While not in IDLE, i_req is ignored; the transaction in flight is unaffected by later requests or input changes.
REQ-012 A requester deasserts i_req, or presents a new request, in the cycle after o_gnt. An i_req still high is treated as a new request.
REQ-013 Byte_we nonzero together with read_en=1: the transaction is a write and read_en is ignored.
REQ-014 o_rdata holds its last value between o_rvalid pulses.

Reset
REQ-015 Reset is asynchronous assert, synchronous deassert by the system. On reset:
- state=IDLE
- all outputs 0
- latched fields 0
- round-robin pointer = requester 0 last-granted, so requester 1 wins first contention
REQ-016 Reset during ISSUE or RESP aborts the transaction; no o_rvalid is issued afterwards.

Configuration
REQ-017 Macro MMIO_ARB_ROUND_ROBIN_EN defined: on contention, grant the requester not granted last. Single requests are always granted. The pointer updates on every grant.
REQ-018 Macro MMIO_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins contention; no pointer register exists.

Structure
REQ-019 Package mmio_arb_pkg holds:
- the FSM state enum
- ADDR_W and DATA_W defaults
- a packed txn struct {addr, wdata, byte_we, read_en}
REQ-020 One combinational sub-module, mmio_arb_pick, computes the winner from i_req and the pointer. It contains the macro-dependent logic.

Verification
REQ-021 Requester 0 writes addr 0, data 0xDEADBEEF, byte_we 4'hF -> o_gnt=2'b01 at T+1; at T+2 o_addr=0, o_data=0xDEADBEEF, o_byte_we=F for one cycle; nothing else.
REQ-022 Requester 1 reads addr 5, read_en=1, with downstream returning 0x41 -> o_read_en high for exactly one cycle; o_rvalid=2'b10 and o_rdata=0x41 two cycles after grant.
REQ-023 Both request continuously, with the macro defined -> grants alternate 10,01,10,01. With the macro undefined -> grants are 01,01,01,01.
REQ-024 Requester 0 read in flight; requester 1 raises i_req during RESP -> requester 1 is granted only after o_rvalid[0], and its request is not lost.
REQ-025 Assert i_rst_n=0 during RESP, then release -> all outputs 0 immediately; no o_rvalid after release; the next contention is granted to requester 1 under round-robin.

Source files
------------

// File: rtl/mmio_arb_pkg.sv
// Shared types for the two-requester MMIO arbiter: FSM states, default
// widths and the latched transaction record.
package mmio_arb_pkg;

  localparam int ADDR_W_DEF = 26;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [BE_W_DEF-1:0]   byte_we;
    logic                  read_en;
  } txn_t;

  // A transaction is a write whenever any byte lane is enabled.
  function automatic logic txn_is_write(input txn_t t);
    return |t.byte_we;
  endfunction

endpackage

// File: rtl/mmio_arbiter_if.sv
// Requester-side and downstream-side signals of the MMIO arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface mmio_arbiter_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [1:0]        i_req;
  logic [ADDR_W-1:0] i_addr0;
  logic [ADDR_W-1:0] i_addr1;
  logic [DATA_W-1:0] i_wdata0;
  logic [DATA_W-1:0] i_wdata1;
  logic [BE_W-1:0]   i_byte_we0;
  logic [BE_W-1:0]   i_byte_we1;
  logic              i_read_en0;
  logic              i_read_en1;
  logic [1:0]        o_gnt;
  logic [1:0]        o_rvalid;
  logic [DATA_W-1:0] o_rdata;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_data;
  logic [BE_W-1:0]   o_byte_we;
  logic              o_read_en;
  logic [DATA_W-1:0] i_rdata;

  modport slave (
    input  i_req, i_addr0, i_addr1, i_wdata0, i_wdata1,
           i_byte_we0, i_byte_we1, i_read_en0, i_read_en1, i_rdata,
    output o_gnt, o_rvalid, o_rdata, o_addr, o_data, o_byte_we, o_read_en
  );

  modport master (
    output i_req, i_addr0, i_addr1, i_wdata0, i_wdata1,
           i_byte_we0, i_byte_we1, i_read_en0, i_read_en1, i_rdata,
    input  o_gnt, o_rvalid, o_rdata, o_addr, o_data, o_byte_we, o_read_en
  );
endinterface

// File: rtl/mmio_arb_pick.sv
// Combinational winner selection for two requesters.
// MMIO_ARB_ROUND_ROBIN_EN: contention goes to the requester not granted
// last; otherwise requester 0 always wins contention.
module mmio_arb_pick (
  input  logic [1:0] i_req,
`ifdef MMIO_ARB_ROUND_ROBIN_EN
  input  logic       i_last,
`endif
  output logic       o_win
);

  // Select the winning requester index from the request vector.
  always_comb begin
    o_win = 1'b0;
    case (i_req)
      2'b01:   o_win = 1'b0;
      2'b10:   o_win = 1'b1;
`ifdef MMIO_ARB_ROUND_ROBIN_EN
      2'b11:   o_win = ~i_last;
`else
      2'b11:   o_win = 1'b0;
`endif
      default: o_win = 1'b0;
    endcase
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Two-requester MMIO arbiter: accept one request, issue a single
// downstream access, and for reads return the data one cycle later.
// Optional MMIO_ARB_ROUND_ROBIN_EN selects round-robin contention.
module mmio_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  mmio_arbiter_if.slave   bus
);

  localparam int BE_W = DATA_W / 8;

  state_t r_state;
  txn_t   r_txn;
  logic   r_win;
  logic   w_win;
  txn_t   w_txn_sel;

`ifdef MMIO_ARB_ROUND_ROBIN_EN
  // Last-granted requester; reset to 0 so requester 1 wins first contention.
  logic   r_last;

  mmio_arb_pick u_pick (
    .i_req  (bus.i_req),
    .i_last (r_last),
    .o_win  (w_win)
  );

  // Pointer follows every grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b0;
    end else if ((r_state == ST_IDLE) && (|bus.i_req)) begin
      r_last <= w_win;
    end else begin
      r_last <= r_last;
    end
  end
`else
  mmio_arb_pick u_pick (
    .i_req  (bus.i_req),
    .o_win  (w_win)
  );
`endif

  // Gather the winning requester's fields into one record.
  always_comb begin
    w_txn_sel = '0;
    if (w_win) begin
      w_txn_sel.addr    = bus.i_addr1;
      w_txn_sel.wdata   = bus.i_wdata1;
      w_txn_sel.byte_we = bus.i_byte_we1;
      w_txn_sel.read_en = bus.i_read_en1;
    end else begin
      w_txn_sel.addr    = bus.i_addr0;
      w_txn_sel.wdata   = bus.i_wdata0;
      w_txn_sel.byte_we = bus.i_byte_we0;
      w_txn_sel.read_en = bus.i_read_en0;
    end
  end

  // Transaction FSM; all outputs are registered pulses, zero by default.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_txn         <= '0;
      r_win         <= 1'b0;
      bus.o_gnt     <= 2'b00;
      bus.o_rvalid  <= 2'b00;
      bus.o_rdata   <= {DATA_W{1'b0}};
      bus.o_addr    <= {ADDR_W{1'b0}};
      bus.o_data    <= {DATA_W{1'b0}};
      bus.o_byte_we <= {BE_W{1'b0}};
      bus.o_read_en <= 1'b0;
    end else begin
      bus.o_gnt     <= 2'b00;
      bus.o_rvalid  <= 2'b00;
      bus.o_addr    <= {ADDR_W{1'b0}};
      bus.o_data    <= {DATA_W{1'b0}};
      bus.o_byte_we <= {BE_W{1'b0}};
      bus.o_read_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|bus.i_req) begin
            r_win     <= w_win;
            r_txn     <= w_txn_sel;
            bus.o_gnt <= w_win ? 2'b10 : 2'b01;
            r_state   <= ST_ISSUE;
          end else begin
            r_state   <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          bus.o_addr    <= r_txn.addr;
          bus.o_data    <= r_txn.wdata;
          bus.o_byte_we <= r_txn.byte_we;
          if (txn_is_write(r_txn)) begin
            // Byte enables win over a simultaneous read strobe.
            bus.o_read_en <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            bus.o_read_en <= r_txn.read_en;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          bus.o_rdata  <= bus.i_rdata;
          bus.o_rvalid <= r_win ? 2'b10 : 2'b01;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed, table-driven bench for mmio_arbiter, plus hand sequences for
// contention, requests arriving mid-transaction and reset during RESP.
module tb_mmio_arbiter;

`ifdef MMIO_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mmio_arbiter_if #(.ADDR_W(26), .DATA_W(32)) bus ();

  mmio_arbiter dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [25:0] a0;  logic [31:0] d0; logic [3:0] be0; logic re0;
    logic [25:0] a1;  logic [31:0] d1; logic [3:0] be1; logic re1;
    logic [31:0] rdata;
    logic [1:0]  exp_gnt;
    logic [25:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic        exp_re;
    logic        is_read;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [62:0] ds();
    return {bus.o_addr, bus.o_data, bus.o_byte_we, bus.o_read_en};
  endfunction

  function automatic logic [98:0] all_out();
    return {bus.o_gnt, bus.o_rvalid, bus.o_rdata, ds()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req = 2'b00;
    bus.i_addr0 = 26'd0; bus.i_wdata0 = 32'd0; bus.i_byte_we0 = 4'h0; bus.i_read_en0 = 1'b0;
    bus.i_addr1 = 26'd0; bus.i_wdata1 = 32'd0; bus.i_byte_we1 = 4'h0; bus.i_read_en1 = 1'b0;
    bus.i_rdata = 32'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_outputs", all_out(), 99'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("after_reset_outputs", all_out(), 99'd0);
  endtask

  logic [31:0] m_rdata;
  logic        m_last;
  logic [1:0]  exp_g;
  logic [1:0]  prev_g;
  int          n_gnt;
  int          n_rv;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b1;
    m_rdata  = 32'd0;

    //            req    a0           d0            be0   re0   a1          d1            be1   re1   rdata         gnt    addr         data          be    re    rd
    vecs[0] = '{2'b01, 26'd0,       32'hDEADBEEF, 4'hF, 1'b0, 26'h55,     32'hFFFF0000, 4'h3, 1'b1, 32'h0,        2'b01, 26'd0,       32'hDEADBEEF, 4'hF, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 26'h99,      32'h11111111, 4'hF, 1'b1, 26'd5,      32'h0,        4'h0, 1'b1, 32'h41,       2'b10, 26'd5,       32'h0,        4'h0, 1'b1, 1'b1};
    vecs[2] = '{2'b01, 26'h3FFFFFF, 32'h12345678, 4'h5, 1'b1, 26'h1,      32'h2,        4'h0, 1'b1, 32'hBAD,      2'b01, 26'h3FFFFFF, 32'h12345678, 4'h5, 1'b0, 1'b0};
    vecs[3] = '{2'b01, 26'h123,     32'h0,        4'h0, 1'b1, 26'h7,      32'h3,        4'hF, 1'b0, 32'hA5A5A5A5, 2'b01, 26'h123,     32'h0,        4'h0, 1'b1, 1'b1};
    vecs[4] = '{2'b10, 26'h2,       32'h4,        4'h0, 1'b1, 26'h7,      32'hCAFEF00D, 4'h8, 1'b0, 32'h0,        2'b10, 26'h7,       32'hCAFEF00D, 4'h8, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 26'h0,       32'h0,        4'h0, 1'b0, 26'h9,      32'h0,        4'h0, 1'b0, 32'h77,       2'b10, 26'h9,       32'h0,        4'h0, 1'b0, 1'b1};

    do_reset();

    // Single transactions from the table.
    for (int k = 0; k < 6; k++) begin
      bus.i_addr0 = vecs[k].a0; bus.i_wdata0 = vecs[k].d0; bus.i_byte_we0 = vecs[k].be0; bus.i_read_en0 = vecs[k].re0;
      bus.i_addr1 = vecs[k].a1; bus.i_wdata1 = vecs[k].d1; bus.i_byte_we1 = vecs[k].be1; bus.i_read_en1 = vecs[k].re1;
      bus.i_rdata = vecs[k].rdata;
      bus.i_req   = vecs[k].req;
      tick();
      chk($sformatf("v%0d_gnt", k), bus.o_gnt, vecs[k].exp_gnt);
      chk($sformatf("v%0d_ds_before_access", k), ds(), 63'd0);
      bus.i_req = 2'b00;
      tick();
      chk($sformatf("v%0d_access", k), ds(),
          {vecs[k].exp_addr, vecs[k].exp_data, vecs[k].exp_be, vecs[k].exp_re});
      chk($sformatf("v%0d_gnt_single_pulse", k), bus.o_gnt, 2'b00);
      tick();
      chk($sformatf("v%0d_ds_single_cycle", k), ds(), 63'd0);
      if (vecs[k].is_read) begin
        m_rdata = vecs[k].rdata;
        chk($sformatf("v%0d_rvalid", k), bus.o_rvalid, vecs[k].exp_gnt);
      end else begin
        chk($sformatf("v%0d_no_rvalid", k), bus.o_rvalid, 2'b00);
      end
      chk($sformatf("v%0d_rdata", k), bus.o_rdata, m_rdata);
      tick();
      chk($sformatf("v%0d_rvalid_single_pulse", k), bus.o_rvalid, 2'b00);
      chk($sformatf("v%0d_rdata_hold", k), bus.o_rdata, m_rdata);
    end

    // Continuous contention right after reset.
    do_reset();
    m_last = 1'b0;
    bus.i_addr0 = 26'h10; bus.i_wdata0 = 32'h1111; bus.i_byte_we0 = 4'hF;
    bus.i_addr1 = 26'h20; bus.i_wdata1 = 32'h2222; bus.i_byte_we1 = 4'hF;
    bus.i_req = 2'b11;
    n_gnt  = 0;
    prev_g = 2'b00;
    for (int c = 0; c < 16 && n_gnt < 4; c++) begin
      tick();
      if (prev_g != 2'b00) begin
        chk("cont_access_addr", bus.o_addr, (prev_g == 2'b10) ? 26'h20 : 26'h10);
      end
      if (bus.o_gnt != 2'b00) begin
        exp_g  = (RR && !m_last) ? 2'b10 : 2'b01;
        chk($sformatf("cont_gnt%0d", n_gnt), bus.o_gnt, exp_g);
        m_last = (exp_g == 2'b10);
        n_gnt++;
      end
      prev_g = bus.o_gnt;
    end
    chk("cont_grant_count", n_gnt, 4);
    bus.i_req = 2'b00;
    tick();
    tick();
    tick();

    // Requester 1 arrives while requester 0's read is in RESP.
    clear_inputs();
    bus.i_addr0 = 26'h30; bus.i_read_en0 = 1'b1; bus.i_rdata = 32'h5EED;
    bus.i_addr1 = 26'h31; bus.i_wdata1 = 32'hABCD; bus.i_byte_we1 = 4'h3;
    bus.i_req = 2'b01;
    tick();
    chk("mid_gnt0", bus.o_gnt, 2'b01);
    bus.i_req = 2'b00;
    tick();
    chk("mid_read_strobe", bus.o_read_en, 1'b1);
    bus.i_req = 2'b10;
    tick();
    chk("mid_rvalid0", bus.o_rvalid, 2'b01);
    chk("mid_rdata0", bus.o_rdata, 32'h5EED);
    chk("mid_no_early_gnt1", bus.o_gnt, 2'b00);
    tick();
    chk("mid_gnt1", bus.o_gnt, 2'b10);
    bus.i_req = 2'b00;
    tick();
    chk("mid_access1", ds(), {26'h31, 32'hABCD, 4'h3, 1'b0});
    tick();

    // Reset while requester 1's read is in RESP.
    clear_inputs();
    bus.i_addr1 = 26'h40; bus.i_read_en1 = 1'b1; bus.i_rdata = 32'h99;
    bus.i_req = 2'b10;
    tick();
    chk("rst_gnt1", bus.o_gnt, 2'b10);
    bus.i_req = 2'b00;
    tick();
    chk("rst_strobe_before", bus.o_read_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs_immediate", all_out(), 99'd0);
    tick();
    rst_n = 1'b1;
    n_rv = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.o_rvalid != 2'b00) n_rv++;
    end
    chk("rst_no_rvalid_after", n_rv, 0);
    bus.i_addr0 = 26'h50; bus.i_byte_we0 = 4'hF;
    bus.i_addr1 = 26'h51; bus.i_byte_we1 = 4'hF;
    bus.i_req = 2'b11;
    tick();
    chk("rst_next_contention", bus.o_gnt, RR ? 2'b10 : 2'b01);
    bus.i_req = 2'b00;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
